// File: rtl/reg_c_pkg.sv
// Shared types and helpers for the reg_c_fold cyclic XOR-fold register.
package reg_c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] fold_vec_t;

    // One serial step on a w-bit register held in the low bits of r: shift toward
    // bit 0 and drop the injected XOR into bit w-1. Upper bits of r must be zero.
    function automatic fold_vec_t fold_step(input fold_vec_t r, input logic b, input int w);
        return (r >> 1) | (fold_vec_t'(b ^ r[0]) << (w - 1));
    endfunction

    function automatic bit cw_fits(input int cw, input int len, input int p);
        return cw >= $clog2(len + p + 1);
    endfunction

endpackage

// File: rtl/reg_c_fold_step.sv
// Combinational P-stage unrolled fold: applies m (<= P) serial steps starting at step index count.
module reg_c_fold_step
    import reg_c_pkg::*;
#(
    parameter int N         = 64,
    parameter int W         = 15,
    parameter int P         = 1,
    parameter int CW        = 11,
    parameter int MSB_FIRST = 1
) (
    input  logic [W-1:0]  reg_q,
    input  logic [N-1:0]  shadow,
    input  logic [CW-1:0] count,
    input  logic [CW-1:0] m,
    output logic [W-1:0]  reg_next
);

    logic [N-1:0]  ordered;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] k;
    logic          b;

    // Reorder once so step k always reads bit k; indices >= N shift out to zero.
    for (genvar j = 0; j < N; j++) begin : g_order
        if (MSB_FIRST != 0) begin : g_msb
            assign ordered[j] = shadow[N-1-j];
        end else begin : g_lsb
            assign ordered[j] = shadow[j];
        end
    end

    always_comb begin
        r_acc = reg_q;
        k     = '0;
        b     = 1'b0;
        for (int i = 0; i < P; i++) begin
            k = count + CW'(i);
            b = |(ordered & (N'(1) << k));
            if (CW'(i) < m) begin
                r_acc = W'(fold_step(fold_vec_t'(r_acc), b, W));
            end
        end
        reg_next = r_acc;
    end

endmodule

// File: rtl/reg_c_fold.sv
// Parametrised cyclic XOR-fold register with start/busy/done handshake.
module reg_c_fold
    import reg_c_pkg::*;
#(
    parameter int N         = 64,
    parameter int W         = 15,
    parameter int P         = 1,
    parameter int LEN       = 64,
    parameter int MSB_FIRST = 1,
    parameter int CW        = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          en,
    input  logic [N-1:0]  data_in,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic [W-1:0]  data_out
);

    localparam logic [CW-1:0] LEN_C = CW'(LEN);
    localparam logic [CW-1:0] P_C   = CW'(P);

    if (!cw_fits(CW, LEN, P)) begin : g_cw_check
        $error("reg_c_fold: CW too narrow for LEN + P");
    end

    state_t        state;
    logic [N-1:0]  shadow;
    logic [CW-1:0] rem;
    logic [CW-1:0] m;
    logic [CW-1:0] next_count;
    logic [W-1:0]  fold_next;

    // Last enabled cycle takes only the remaining steps so count lands exactly on LEN.
    assign rem        = LEN_C - count;
    assign m          = (rem < P_C) ? rem : P_C;
    assign next_count = count + m;

    reg_c_fold_step #(
        .N        (N),
        .W        (W),
        .P        (P),
        .CW       (CW),
        .MSB_FIRST(MSB_FIRST)
    ) u_step (
        .reg_q   (data_out),
        .shadow  (shadow),
        .count   (count),
        .m       (m),
        .reg_next(fold_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shadow   <= '0;
            data_out <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            state    <= RUN;
            shadow   <= data_in;
            data_out <= '0;
            count    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (en) begin
                        data_out <= fold_next;
                        count    <= next_count;
                        if (next_count == LEN_C) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_c_fold.sv
// Self-checking bench for reg_c_fold: three configurations driven in parallel against a closed-form fold model.
module tb_reg_c_fold;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        en = 1'b0;
    logic [63:0] data_in = '0;

    logic        bsy [3];
    logic        dn  [3];
    logic [10:0] cnt [3];
    logic [14:0] dout[3];

    int vectors = 0;
    int miscompares = 0;

    int          st [3];
    int          mc [3];
    logic [63:0] m_data = '0;

    always #5 clk = ~clk;

    reg_c_fold #(.N(64), .W(15), .P(1), .LEN(64), .MSB_FIRST(1), .CW(11)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .data_in(data_in),
        .busy(bsy[0]), .done(dn[0]), .count(cnt[0]), .data_out(dout[0])
    );

    reg_c_fold #(.N(64), .W(15), .P(1), .LEN(64), .MSB_FIRST(0), .CW(11)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .data_in(data_in),
        .busy(bsy[1]), .done(dn[1]), .count(cnt[1]), .data_out(dout[1])
    );

    reg_c_fold #(.N(64), .W(15), .P(4), .LEN(66), .MSB_FIRST(1), .CW(11)) dut_p4 (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .data_in(data_in),
        .busy(bsy[2]), .done(dn[2]), .count(cnt[2]), .data_out(dout[2])
    );

    function automatic int p_of(input int i);
        return (i == 2) ? 4 : 1;
    endfunction

    function automatic int len_of(input int i);
        return (i == 2) ? 66 : 64;
    endfunction

    function automatic bit msb_of(input int i);
        return i != 1;
    endfunction

    // Closed form: a bit injected at step k has rotated (steps-1-k) places down from bit 14.
    function automatic logic [14:0] fold_ref(input logic [63:0] d, input int steps, input bit msb);
        logic [14:0] r;
        int pos;
        r = '0;
        for (int k = 0; k < steps && k < 64; k++) begin
            if (((msb ? (d >> (63 - k)) : (d >> k)) & 64'd1) != 64'd0) begin
                pos = (14 - (steps - 1 - k)) % 15;
                if (pos < 0) pos += 15;
                r ^= 15'(1) << pos;
            end
        end
        return r;
    endfunction

    task automatic step(input logic s, input logic e);
        int m;
        start = s;
        en    = e;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (s) begin
                st[i] = 1;
                mc[i] = 0;
            end else if (st[i] == 1 && e) begin
                m = (len_of(i) - mc[i] < p_of(i)) ? len_of(i) - mc[i] : p_of(i);
                mc[i] += m;
                if (mc[i] == len_of(i)) st[i] = 2;
            end else if (st[i] == 2) begin
                st[i] = 0;
            end
        end
        if (s) m_data = data_in;
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 0;
            mc[i] = 0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dout[i] !== 15'h0 || cnt[i] !== 11'd0 || bsy[i] !== 1'b0 || dn[i] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset[%0d]: got dout=%h cnt=%0d busy=%b done=%b, want all zero",
                         i, dout[i], cnt[i], bsy[i], dn[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_msb_word();
        int done_seen = 0;
        data_in = 64'h8000_0000_0000_0000;
        step(1'b1, 1'b0);
        vectors++;
        if (bsy[0] !== 1'b1 || cnt[0] !== 11'd0 || dout[0] !== 15'h0) begin
            miscompares++;
            $display("[TB] FAIL load: got busy=%b cnt=%0d dout=%h, want 1 0 0000", bsy[0], cnt[0], dout[0]);
        end
        step(1'b0, 1'b1);
        vectors++;
        if (dout[0] !== 15'h4000 || cnt[0] !== 11'd1) begin
            miscompares++;
            $display("[TB] FAIL first_step: got dout=%h cnt=%0d, want 4000 1", dout[0], cnt[0]);
        end
        for (int j = 2; j <= 64; j++) begin
            step(1'b0, 1'b1);
            if (dn[0] === 1'b1) done_seen++;
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (cnt[i] !== 11'(mc[i]) || dout[i] !== fold_ref(m_data, mc[i], msb_of(i)) ||
                    bsy[i] !== (st[i] == 1) || dn[i] !== (st[i] == 2)) begin
                    miscompares++;
                    $display("[TB] FAIL msb_run[%0d] step %0d: got cnt=%0d dout=%h busy=%b done=%b, want cnt=%0d dout=%h busy=%b done=%b",
                             i, j, cnt[i], dout[i], bsy[i], dn[i], mc[i],
                             fold_ref(m_data, mc[i], msb_of(i)), st[i] == 1, st[i] == 2);
                end
            end
        end
        vectors++;
        if (dout[0] !== 15'h0800 || cnt[0] !== 11'd64 || dn[0] !== 1'b1 || dout[1] !== 15'h4000) begin
            miscompares++;
            $display("[TB] FAIL msb_final: got dout=%h cnt=%0d done=%b lsb_dout=%h, want 0800 64 1 4000",
                     dout[0], cnt[0], dn[0], dout[1]);
        end
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 1'b1);
            if (dn[0] === 1'b1) done_seen++;
        end
        vectors++;
        if (done_seen != 1 || cnt[0] !== 11'd64) begin
            miscompares++;
            $display("[TB] FAIL done_once: got %0d pulses cnt=%0d, want 1 pulse cnt=64", done_seen, cnt[0]);
        end
    endtask

    task automatic test_partial_last();
        data_in = 64'h1;
        step(1'b1, 1'b0);
        for (int j = 1; j <= 64; j++) begin
            step(1'b0, 1'b1);
            if (j == 16) begin
                vectors++;
                if (dn[2] !== 1'b0 || bsy[2] !== 1'b1 || cnt[2] !== 11'd64) begin
                    miscompares++;
                    $display("[TB] FAIL p4_cycle16: got done=%b busy=%b cnt=%0d, want 0 1 64", dn[2], bsy[2], cnt[2]);
                end
            end
            if (j == 17) begin
                vectors++;
                if (dn[2] !== 1'b1 || bsy[2] !== 1'b0 || cnt[2] !== 11'd66 || dout[2] !== 15'h1000) begin
                    miscompares++;
                    $display("[TB] FAIL p4_final: got done=%b busy=%b cnt=%0d dout=%h, want 1 0 66 1000",
                             dn[2], bsy[2], cnt[2], dout[2]);
                end
            end
        end
        vectors++;
        if (dout[0] !== 15'h4000 || dout[1] !== fold_ref(64'h1, 64, 1'b0) || dn[2] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lsb_word1: got msb=%h lsb=%h p4_done=%b, want 4000 %h 0",
                     dout[0], dout[1], dn[2], fold_ref(64'h1, 64, 1'b0));
        end
    endtask

    task automatic test_en_toggle();
        logic [10:0] prev;
        data_in = {$urandom, $urandom};
        step(1'b1, 1'b0);
        for (int j = 1; j <= 130; j++) begin
            prev = cnt[0];
            step(1'b0, 1'((j % 2) == 1));
            vectors++;
            if (dn[0] !== (j == 127) || ((j % 2) == 0 && cnt[0] !== prev)) begin
                miscompares++;
                $display("[TB] FAIL en_toggle step %0d: got done=%b cnt=%0d prev=%0d, want done=%b",
                         j, dn[0], cnt[0], prev, j == 127);
            end
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dout[i] !== fold_ref(m_data, len_of(i), msb_of(i)) || cnt[i] !== 11'(len_of(i))) begin
                miscompares++;
                $display("[TB] FAIL en_toggle_final[%0d]: got dout=%h cnt=%0d, want %h %0d",
                         i, dout[i], cnt[i], fold_ref(m_data, len_of(i), msb_of(i)), len_of(i));
            end
        end
    endtask

    task automatic test_abort();
        int done_seen = 0;
        data_in = {$urandom, $urandom};
        step(1'b1, 1'b0);
        for (int j = 0; j < 30; j++) begin
            step(1'b0, 1'b1);
            if (dn[0] === 1'b1) done_seen++;
        end
        vectors++;
        if (cnt[0] !== 11'd30) begin
            miscompares++;
            $display("[TB] FAIL abort_pre: got cnt=%0d, want 30", cnt[0]);
        end
        data_in = {$urandom, $urandom};
        step(1'b1, 1'b1);
        vectors++;
        if (cnt[0] !== 11'd0 || dout[0] !== 15'h0 || bsy[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort_reload: got cnt=%0d dout=%h busy=%b, want 0 0000 1", cnt[0], dout[0], bsy[0]);
        end
        for (int j = 0; j < 66; j++) begin
            step(1'b0, 1'b1);
            if (dn[0] === 1'b1) done_seen++;
        end
        vectors++;
        if (done_seen != 1 || dout[0] !== fold_ref(m_data, 64, 1'b1)) begin
            miscompares++;
            $display("[TB] FAIL abort_result: got %0d done pulses dout=%h, want 1 %h",
                     done_seen, dout[0], fold_ref(m_data, 64, 1'b1));
        end
        step(1'b1, 1'b0);
        for (int j = 0; j < 63; j++) step(1'b0, 1'b1);
        data_in = {$urandom, $urandom};
        step(1'b1, 1'b1);
        vectors++;
        if (cnt[0] !== 11'd0 || bsy[0] !== 1'b1 || dn[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL restart_final: got cnt=%0d busy=%b done=%b, want 0 1 0", cnt[0], bsy[0], dn[0]);
        end
        step(1'b0, 1'b0);
        vectors++;
        if (dn[0] !== 1'b0 || cnt[0] !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL restart_no_done: got done=%b cnt=%0d, want 0 0", dn[0], cnt[0]);
        end
    endtask

    task automatic test_async_reset();
        data_in = {$urandom, $urandom};
        step(1'b1, 1'b0);
        for (int j = 0; j < 20; j++) step(1'b0, 1'b1);
        vectors++;
        if (cnt[0] !== 11'd20) begin
            miscompares++;
            $display("[TB] FAIL async_pre: got cnt=%0d, want 20", cnt[0]);
        end
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            st[i] = 0;
            mc[i] = 0;
            vectors++;
            if (dout[i] !== 15'h0 || cnt[i] !== 11'd0 || bsy[i] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL async_clear[%0d]: got dout=%h cnt=%0d busy=%b, want 0 0 0",
                         i, dout[i], cnt[i], bsy[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 1'b1);
            vectors++;
            if (cnt[0] !== 11'd0 || bsy[0] !== 1'b0 || dout[0] !== 15'h0) begin
                miscompares++;
                $display("[TB] FAIL en_without_start: got cnt=%0d busy=%b dout=%h, want 0 0 0000",
                         cnt[0], bsy[0], dout[0]);
            end
        end
    endtask

    task automatic test_random();
        int iter;
        for (int run = 0; run < 4; run++) begin
            data_in = {$urandom, $urandom};
            step(1'b1, 1'b0);
            iter = 0;
            while ((st[0] != 0 || st[1] != 0 || st[2] != 0) && iter < 400) begin
                step(1'b0, 1'($urandom_range(0, 3) != 0));
                iter++;
                for (int i = 0; i < 3; i++) begin
                    vectors++;
                    if (cnt[i] !== 11'(mc[i]) || dout[i] !== fold_ref(m_data, mc[i], msb_of(i)) ||
                        bsy[i] !== (st[i] == 1) || dn[i] !== (st[i] == 2)) begin
                        miscompares++;
                        $display("[TB] FAIL random[%0d] run %0d iter %0d: got cnt=%0d dout=%h busy=%b done=%b, want cnt=%0d dout=%h",
                                 i, run, iter, cnt[i], dout[i], bsy[i], dn[i], mc[i],
                                 fold_ref(m_data, mc[i], msb_of(i)));
                    end
                end
            end
            vectors++;
            if (iter >= 400) begin
                miscompares++;
                $display("[TB] FAIL random_timeout run %0d: got %0d cycles, want completion", run, iter);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_word();
        test_partial_last();
        test_en_toggle();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_c_fold.md
Name: reg_c_fold

Overview:
Parametrised successor of the serial 15-bit cyclic XOR-fold register. Latches an N-bit word on `start`, then folds it into a W-bit circular register, P bits per enabled cycle. Bit order is selectable, and the fold length LEN may exceed N (zero-padding). Provides a start/busy/done handshake so the checksum/syndrome stage sequences it without an external bit counter.

Parameters:
N, 64, input word width in bits
W, 15, fold register width
P, 1, single-bit fold steps per enabled cycle; 1 <= P <= W
LEN, 64, total fold steps per run; LEN >= 1; input bits with index >= N read as 0
MSB_FIRST, 1, 1: step k consumes data[N-1-k]; 0: step k consumes data[k]
CW, 11, count width; must satisfy 2**CW > LEN + P

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  pulse: latch data_in, clear register and count, enter RUN
en  input  1  advance one cycle (P steps) while in RUN
data_in  input  N  word to fold, sampled only on start
busy  output  1  high in RUN
done  output  1  one-cycle pulse on the cycle after the final step
count  output  CW  fold steps performed in current/last run
data_out  output  W  fold register contents

Behaviour:
- Reset (rst_n=0, async): state=IDLE, shadow word=0, data_out=0, count=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE: outputs hold their last values; start -> RUN.
- RUN: busy=1. The cycle with start=1 only loads: shadow<=data_in, reg<=0, count<=0; no fold step that cycle.
- Single fold step k, with r the current register:
  - b = 0 if k >= N, else the data bit selected by MSB_FIRST.
  - r_next = {b ^ r[0], r[W-1:1]}: shift toward bit 0, injected XOR enters the MSB.
- Each RUN cycle with en=1 applies m = min(P, LEN-count) successive steps combinationally, then count <= count+m.
- Result is bit-identical to m serial single-bit shifts.
- en=0 in RUN: register and count hold.
- When count+m == LEN: next state DONE. DONE lasts exactly one cycle, with done=1 and busy=0; then IDLE.
- count never exceeds LEN. The final cycle performs a partial step when LEN mod P != 0.
- start in RUN or DONE: aborts and restarts (reload) that cycle. No done pulse is issued for the aborted run. If start coincides with the final step, the restart wins.
- en is ignored in IDLE and DONE.
- rst_n low mid-run: immediate clear to reset values. First run after rst_n release needs start.
- Latency: LEN/P rounded up enabled cycles from the start cycle to the final step; done one cycle later.

Decomposition:
- Package reg_c_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - a function fold_step(r, b) returning the W-bit next value;
  - a function clog2-based check constant for CW.
- One sub-module is natural: reg_c_fold_step, a combinational P-stage unrolled chain taking reg, shadow, count and m, producing next reg.
- Everything else (FSM, count, shadow) stays in the top.

Test Plan:
- N=64, W=15, P=1, LEN=64, MSB_FIRST=1, data_in=64'h8000_0000_0000_0000, en=1 constant -> after step 1 data_out=15'h4000; after 64 enabled cycles data_out=15'h0800, count=64, done pulses once.
- Same config, data_in=64'h1 -> data_out=15'h4000 at count=64; MSB_FIRST=0 with data_in=64'h8000_0000_0000_0000 gives the same 15'h4000.
- P=4, LEN=66, data_in=64'h1, MSB_FIRST=1 -> 17 enabled cycles; final cycle does 2 steps; data_out=15'h1000, count=66; done on cycle 18.
- P=1 run with en toggling 1/0 every cycle -> 128 cycles to completion; final data_out matches the continuous-en run; count frozen whenever en=0.
- start reasserted at count=30 with a new data_in -> count returns to 0, no done for the first run, final result equals a clean run on the new word.
- rst_n pulsed low at count=20 (asynchronously, mid-cycle) -> data_out=0, count=0, busy=0 immediately; en alone without start performs no steps.
